// File: rtl/delay_timer_bank.sv
// delay_timer_bank: N independent one-shot delay channels.
//   Each channel loads a W-bit length on start, counts ticks down to zero and
//   then emits a single-clk expiry pulse. A tick is one_ms when USE_MS=1, or
//   every clk when USE_MS=0. RETRIG selects whether a start during RUN reloads
//   the counter (1) or is dropped and recorded in the sticky missed flag (0).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   one_ms          single-clk millisecond tick strobe
//   start[N]        per-channel start request
//   cancel[N]       per-channel abort, beats start
//   len[N*W]        channel i length at len[i*W +: W], sampled on accepted start
//   pulse[N]        registered one-clk expiry pulse
//   busy[N]         channel is in RUN
//   missed[N]       sticky: a start was dropped while running
//   any_pulse       registered OR of the pulse bits

module delay_timer_ch #(
  parameter int W      = 10,
  parameter int RETRIG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic         start_i,
  input  logic         cancel_i,
  input  logic [W-1:0] len_i,
  output logic         pulse_o,
  output logic         pulse_d_o,
  output logic         busy_o,
  output logic         missed_o
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ctr_q, ctr_d;
  logic         pulse_q, pulse_d;
  logic         missed_q, missed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    pulse_d  = 1'b0;
    missed_d = missed_q;
    case (state_q)
      IDLE: begin
        if (start_i && !cancel_i) begin
          state_d  = RUN;
          ctr_d    = len_i;
          missed_d = 1'b0;
        end
      end
      RUN: begin
        if (cancel_i) begin
          // abort wins even in the expiry cycle: no pulse
          state_d = IDLE;
        end else if (start_i && (RETRIG != 0)) begin
          // reload beats both decrement and expiry
          ctr_d = len_i;
        end else begin
          if (start_i) missed_d = 1'b1;
          if (ctr_q == '0) begin
            state_d = IDLE;
            pulse_d = 1'b1;
          end else if (tick_i) begin
            // only decrements when nonzero, so never wraps
            ctr_d = ctr_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;
  assign busy_o    = (state_q == RUN);
  assign missed_o  = missed_q;
endmodule

module delay_timer_bank #(
  parameter int N      = 4,
  parameter int W      = 10,
  parameter int USE_MS = 1,
  parameter int RETRIG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           one_ms,
  input  logic [N-1:0]   start,
  input  logic [N-1:0]   cancel,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   pulse,
  output logic [N-1:0]   busy,
  output logic [N-1:0]   missed,
  output logic           any_pulse
);
  logic         tick;
  logic [N-1:0] pulse_nxt;
  logic         any_q;

  assign tick = (USE_MS != 0) ? one_ms : 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_ch
    delay_timer_ch #(
      .W      (W),
      .RETRIG (RETRIG)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .start_i   (start[i]),
      .cancel_i  (cancel[i]),
      .len_i     (len[i*W +: W]),
      .pulse_o   (pulse[i]),
      .pulse_d_o (pulse_nxt[i]),
      .busy_o    (busy[i]),
      .missed_o  (missed[i])
    );
  end

  // registered from the per-channel next-pulse terms so it lines up with pulse
  always_ff @(posedge clk) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |pulse_nxt;
  end

  assign any_pulse = any_q;
endmodule

// File: tb/tb_delay_timer_bank.sv
// Bench: two configurations (ms-tick/no-retrigger and clk-tick/retrigger)
// share one stimulus stream. Each cycle the driver advances a deadline model
// per configuration and queues the expected outputs; a monitor pops and
// compares after the following clock edge.

module tb_delay_timer_bank;
  localparam int N = 4;
  localparam int W = 10;

  typedef struct {
    logic [N-1:0] pulse;
    logic [N-1:0] busy;
    logic [N-1:0] missed;
    logic         any;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           one_ms = 1'b0;
  logic [N-1:0]   start = '0;
  logic [N-1:0]   cancel = '0;
  logic [N*W-1:0] len = '0;

  logic [N-1:0] pulse_a, busy_a, missed_a, pulse_b, busy_b, missed_b;
  logic         any_a, any_b;

  delay_timer_bank #(.N(N), .W(W), .USE_MS(1), .RETRIG(0)) dut_a (
    .clk(clk), .rst(rst), .one_ms(one_ms), .start(start), .cancel(cancel),
    .len(len), .pulse(pulse_a), .busy(busy_a), .missed(missed_a),
    .any_pulse(any_a));

  delay_timer_bank #(.N(N), .W(W), .USE_MS(0), .RETRIG(1)) dut_b (
    .clk(clk), .rst(rst), .one_ms(one_ms), .start(start), .cancel(cancel),
    .len(len), .pulse(pulse_b), .busy(busy_b), .missed(missed_b),
    .any_pulse(any_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ms_rand = 1'b0;

  exp_t qa[$];
  exp_t qb[$];

  // Deadline model: a running channel has a target tick count and the ticks
  // it has already consumed; once consumed == target it expires one clk later.
  bit use_ms_cfg [2] = '{1'b1, 1'b0};
  bit retrig_cfg [2] = '{1'b0, 1'b1};
  bit m_run    [2][N];
  int m_target [2][N];
  int m_used   [2][N];
  bit m_missed [2][N];
  bit m_pulse  [2][N];

  task automatic model_step(input int k, input bit r, input logic [N-1:0] s,
                            input logic [N-1:0] c, input logic [N*W-1:0] l,
                            input bit ms, output exp_t e);
    bit tick;
    tick = use_ms_cfg[k] ? ms : 1'b1;
    for (int i = 0; i < N; i++) begin
      m_pulse[k][i] = 1'b0;
      if (r) begin
        m_run[k][i] = 1'b0; m_used[k][i] = 0; m_missed[k][i] = 1'b0;
      end else if (!m_run[k][i]) begin
        if (s[i] && !c[i]) begin
          m_run[k][i] = 1'b1; m_target[k][i] = int'(l[i*W +: W]);
          m_used[k][i] = 0; m_missed[k][i] = 1'b0;
        end
      end else if (c[i]) begin
        m_run[k][i] = 1'b0;
      end else if (s[i] && retrig_cfg[k]) begin
        m_target[k][i] = int'(l[i*W +: W]); m_used[k][i] = 0;
      end else begin
        if (s[i]) m_missed[k][i] = 1'b1;
        if (m_used[k][i] >= m_target[k][i]) begin
          m_run[k][i] = 1'b0; m_pulse[k][i] = 1'b1;
        end else if (tick) begin
          m_used[k][i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      e.pulse[i]  = m_pulse[k][i];
      e.busy[i]   = m_run[k][i];
      e.missed[i] = m_missed[k][i];
    end
    e.any = |e.pulse;
  endtask

  task automatic step(input bit r, input logic [N-1:0] s, input logic [N-1:0] c,
                      input logic [N*W-1:0] l);
    exp_t ea, eb;
    bit ms;
    @(negedge clk);
    cyc++;
    ms = ms_rand ? ($urandom_range(0, 3) == 0) : ((cyc % 8) == 0);
    rst = r; start = s; cancel = c; len = l; one_ms = ms;
    model_step(0, r, s, c, l, ms, ea);
    model_step(1, r, s, c, l, ms, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic idle(input int n, input logic [N*W-1:0] l);
    repeat (n) step(1'b0, '0, '0, l);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // monitor: one expected record per clock edge for each configuration
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_pulse",  32'(pulse_a),  32'(e.pulse));
        check("a_busy",   32'(busy_a),   32'(e.busy));
        check("a_missed", 32'(missed_a), 32'(e.missed));
        check("a_any",    32'(any_a),    32'(e.any));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_pulse",  32'(pulse_b),  32'(e.pulse));
        check("b_busy",   32'(busy_b),   32'(e.busy));
        check("b_missed", 32'(missed_b), 32'(e.missed));
        check("b_any",    32'(any_b),    32'(e.any));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] lv;
    logic [N-1:0]   s, c;
    bit             r;
    lv = '0;

    step(1'b1, 4'hF, 4'h0, lv);           // reset beats start
    idle(0, lv);
    step(1'b1, '0, '0, lv);
    idle(4, lv);

    lv[0 +: W] = 10'd5;                    // ch0 len=5
    step(1'b0, 4'b0001, '0, lv);
    idle(60, lv);

    lv[W +: W] = 10'd3;                    // ch1 len=3 over ms ticks
    step(1'b0, 4'b0010, '0, lv);
    idle(40, lv);

    lv[2*W +: W] = 10'd4;                  // ch2 restart while running
    step(1'b0, 4'b0100, '0, lv);
    idle(2, lv);
    step(1'b0, 4'b0100, '0, lv);
    idle(50, lv);
    step(1'b0, 4'b0100, '0, lv);           // accepted start clears missed
    idle(50, lv);

    lv[3*W +: W] = 10'd2;                  // cancel on ctr==0 (clk-tick config)
    step(1'b0, 4'b1000, '0, lv);
    idle(2, lv);
    step(1'b0, '0, 4'b1000, lv);
    idle(30, lv);
    step(1'b0, 4'b1000, 4'b1000, lv);      // start+cancel in IDLE
    idle(5, lv);
    step(1'b0, 4'b0001, 4'b0001, lv);      // cancel in IDLE: no effect
    idle(5, lv);

    lv = '0;                               // len=0 everywhere, reset mid-RUN
    step(1'b0, 4'hF, '0, lv);
    step(1'b1, '0, '0, lv);
    idle(10, lv);

    lv = '0;                               // expiry then immediate restart
    lv[0 +: W] = 10'd1;
    step(1'b0, 4'b0001, '0, lv);
    idle(2, lv);
    step(1'b0, 4'b0001, '0, lv);
    idle(30, lv);

    for (int p = 0; p < 2; p++) begin
      ms_rand = (p == 1);
      for (int t = 0; t < 1500; t++) begin
        for (int i = 0; i < N; i++) begin
          s[i] = ($urandom_range(0, 29) == 0);
          c[i] = ($urandom_range(0, 59) == 0);
          lv[i*W +: W] = W'($urandom_range(0, 12));
        end
        r = ($urandom_range(0, 599) == 0);
        step(r, s, c, lv);
      end
    end

    idle(0, lv);
    @(posedge clk);
    #3;
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
